nn_tap_window: RTL and testbench
================================

# nn_tap_window

Input-conditioning stage directly upstream of the three-input NN layer in the neural-network PLL loop filter. Accepts a stream of signed phase-error samples and an arithmetic right shift scales each one to the layer's 9-bit signed input range. It keeps a three-deep delay line of the scaled samples and presents it, together with the layer's registered 8-bit feedback output, as the four 9-bit layer operands. It also flags the first point at which a complete window exists, and every window after that.

## Interface
- `IN_W`, 12, width of incoming signed phase-error sample.
- `SHIFT`, 2, arithmetic right-shift applied to each sample before range reduction (0 ≤ SHIFT < IN_W).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronised to `clk` by the integrator.
- `smp_valid`  in  1  sample strobe; the sample is accepted on any edge where it is high.
- `smp_data`  in  IN_W  signed phase-error sample.
- `fb_in`  in  8  signed layer output fed back (layer operand 4 source).
- `flush`  in  1  synchronous clear of window and counters.
- `tap1`  out  9  signed, newest scaled sample (layer in1).
- `tap2`  out  9  signed, previous sample (layer in2).
- `tap3`  out  9  signed, oldest sample (layer in3).
- `tap4`  out  9  signed, `fb_in` sign-extended and captured at the last accept (layer in4).
- `win_valid`  out  1  one-cycle pulse: taps hold a full, freshly updated window.
- `ovf`  out  1  one-cycle pulse: the last accepted sample was out of 9-bit range.
- `ovf_cnt`  out  8  saturating count of out-of-range samples since reset or flush.

## Operation
- Scaling: `s = smp_data >>> SHIFT`, computed at IN_W bits. The sample is in range when −256 ≤ s ≤ 255. Range reduction to 9 bits is set by the macro described in Configuration.
- On accept:
  - `tap3←tap2`, `tap2←tap1`, `tap1←reduced(s)`.
  - `tap4←{fb_in[7],fb_in}`.
- State machine, states EMPTY, FILL1, FILL2, RUN:
  - Each accept advances EMPTY→FILL1→FILL2→RUN.
  - RUN stays in RUN on further accepts.
  - No accept means hold state.
- `win_valid` is registered. It is high the cycle after an accept whose next state is RUN, i.e. the 3rd and every later accept.
- `ovf` is registered. It is high the cycle after an accept of an out-of-range sample, in every state.
- `ovf_cnt` increments on each out-of-range accept and saturates at 255 (no wrap).
- `flush`, synchronous:
  - Taps 1–4 go to 0, state goes to EMPTY, `ovf_cnt` goes to 0.
  - `win_valid` and `ovf` are 0 the next cycle.
  - `flush` with `smp_valid` in the same cycle: flush wins and the sample is discarded.
- Reset values: all taps 0, state EMPTY, `win_valid` 0, `ovf` 0, `ovf_cnt` 0.
- Reset mid-fill: the window is discarded. After release, 3 new accepts are needed before `win_valid`.

## Timing
- Latency is 1 cycle. Taps, `win_valid` and `ovf` reflect the accept of edge k during cycle k+1.
- The layer is combinational, so its output is valid in the same cycle `win_valid` is high. `fb_in` is sampled only on accept edges.
- Back-to-back accepts every cycle are supported. `win_valid` is then high continuously from the 3rd accept onward.
- There is no backpressure: this block never stalls the sample source.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `NN_TAP_SAT_EN` defined: an out-of-range `s` clamps to +255 or −256.
- Undefined: `reduced(s) = s[8:0]` (two's-complement wrap).
- `ovf` and `ovf_cnt` behave identically in both builds; only the tap value differs.

## Test plan
- Fill (defaults): reset, then accept 400, −400, 100.
  - No `win_valid` after accepts 1–2.
  - After accept 3: tap1=25, tap2=−100, tap3=100, `win_valid` pulse, `ovf`=0.
- Range with `NN_TAP_SAT_EN`: accept 2047 then −2048.
  - tap1 = 255, then −256.
  - `ovf` pulses twice; `ovf_cnt`=2.
- Range without the macro: accept 2047 (s=511).
  - tap1 = −1 (9'h1FF); `ovf` pulses; `ovf_cnt`=1.
- Feedback and streaming: `fb_in`=−128 and `smp_valid` held high for 5 cycles.
  - tap4 = −128 (9'h180).
  - `win_valid` high for cycles 3–5 continuously.
- Flush priority: in RUN, assert `flush` together with `smp_valid`, data 100.
  - Next cycle all taps 0, state EMPTY, `ovf_cnt`=0, sample not loaded.
  - Next 2 accepts give no `win_valid`.
- Async reset mid-fill: drop `rst_n` between clock edges after 2 accepts.
  - Outputs go to 0 immediately, without a clock edge.
  - After release, `win_valid` first appears after the 3rd new accept.
  - Also check that 300 out-of-range accepts leave `ovf_cnt` at 255.

Source files
------------

// File: rtl/nn_tap_window.sv
// ============================================================================
// Module   : nn_tap_window
// Purpose  : Scales phase-error samples to 9 bits and keeps a 3-tap window plus
//            a feedback tap for the NN loop-filter layer. Define NN_TAP_SAT_EN
//            to clamp out-of-range samples; otherwise they wrap to 9 bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_tap_window #(
    parameter int IN_W  = 12,   // must be >= 9
    parameter int SHIFT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   smp_valid,
    input  logic signed [IN_W-1:0] smp_data,
    input  logic signed [7:0]      fb_in,
    input  logic                   flush,
    output logic signed [8:0]      tap1,
    output logic signed [8:0]      tap2,
    output logic signed [8:0]      tap3,
    output logic signed [8:0]      tap4,
    output logic                   win_valid,
    output logic                   ovf,
    output logic [7:0]             ovf_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [8:0] C_POS_MAX = 9'h0FF;
    localparam logic [8:0] C_NEG_MIN = 9'h100;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_accept;
    logic signed [IN_W-1:0]  w_scaled;
    logic [IN_W-9:0]         w_upper;
    logic                    w_in_range;
    logic [8:0]              w_reduced;

    assign w_accept = smp_valid & ~flush;
    assign w_scaled = smp_data >>> SHIFT;

    // In range exactly when every bit above bit 8 replicates the sign bit.
    assign w_upper    = w_scaled[IN_W-1:8];
    assign w_in_range = (&w_upper) | ~(|w_upper);

`ifdef NN_TAP_SAT_EN
    assign w_reduced = w_in_range ? w_scaled[8:0]
                     : (w_scaled[IN_W-1] ? C_NEG_MIN : C_POS_MAX);
`else
    assign w_reduced = w_scaled[8:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                EMPTY:   w_state_nxt = FILL1;
                FILL1:   w_state_nxt = FILL2;
                FILL2:   w_state_nxt = RUN;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap1      <= '0;
            tap2      <= '0;
            tap3      <= '0;
            tap4      <= '0;
            win_valid <= 1'b0;
            ovf       <= 1'b0;
            ovf_cnt   <= '0;
        end else if (flush) begin
            tap1      <= '0;
            tap2      <= '0;
            tap3      <= '0;
            tap4      <= '0;
            win_valid <= 1'b0;
            ovf       <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            win_valid <= w_accept && (w_state_nxt == RUN);
            ovf       <= w_accept && !w_in_range;
            if (w_accept) begin
                tap3 <= tap2;
                tap2 <= tap1;
                tap1 <= w_reduced;
                tap4 <= {fb_in[7], fb_in};
                // Counter saturates rather than wrapping.
                if (!w_in_range && (ovf_cnt != 8'hFF)) begin
                    ovf_cnt <= ovf_cnt + 8'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nn_tap_window.sv
// ============================================================================
// Module   : tb_nn_tap_window
// Purpose  : Directed and random stimulus against a sample-level window model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_tap_window;

    logic              clk;
    logic              rst_n;
    logic              smp_valid;
    logic signed [11:0] smp_data;
    logic signed [7:0] fb_in;
    logic              flush;
    logic signed [8:0] tap1, tap2, tap3, tap4;
    logic              win_valid, ovf;
    logic [7:0]        ovf_cnt;

    int nchk  = 0;
    int npass = 0;

    // reference model state
    int m_win[3];      // newest first
    int m_fb;
    int m_count;       // accepted samples since clear, capped at 3
    int m_ovfcnt;
    int m_winv, m_ovf;

    nn_tap_window #(.IN_W(12), .SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .smp_valid(smp_valid), .smp_data(smp_data),
        .fb_in(fb_in), .flush(flush), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .tap4(tap4), .win_valid(win_valid), .ovf(ovf), .ovf_cnt(ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int floor_div4(input int v);
        int r;
        r = ((v % 4) + 4) % 4;
        return (v - r) / 4;
    endfunction

    function automatic int reduce9(input int s);
`ifdef NN_TAP_SAT_EN
        if (s > 255)  return 255;
        if (s < -256) return -256;
        return s;
`else
        return ((((s + 256) % 512) + 512) % 512) - 256;
`endif
    endfunction

    task automatic model_clear();
        m_win = '{0, 0, 0};
        m_fb = 0; m_count = 0; m_ovfcnt = 0; m_winv = 0; m_ovf = 0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tap1"}, int'(tap1), m_win[0]);
        chk({tag, ".tap2"}, int'(tap2), m_win[1]);
        chk({tag, ".tap3"}, int'(tap3), m_win[2]);
        chk({tag, ".tap4"}, int'(tap4), m_fb);
        chk({tag, ".win_valid"}, int'(win_valid), m_winv);
        chk({tag, ".ovf"}, int'(ovf), m_ovf);
        chk({tag, ".ovf_cnt"}, int'(ovf_cnt), m_ovfcnt);
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input string tag, input bit v, input int data,
                        input int fb, input bit fl);
        int s;
        smp_valid = v;
        smp_data  = data[11:0];
        fb_in     = fb[7:0];
        flush     = fl;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else if (v) begin
            s = floor_div4(int'(smp_data));
            m_win[2] = m_win[1];
            m_win[1] = m_win[0];
            m_win[0] = reduce9(s);
            m_fb     = int'(fb_in);
            m_count  = (m_count < 3) ? m_count + 1 : 3;
            m_winv   = (m_count == 3) ? 1 : 0;
            m_ovf    = (s > 255 || s < -256) ? 1 : 0;
            if (m_ovf == 1 && m_ovfcnt < 255) m_ovfcnt++;
        end else begin
            m_winv = 0;
            m_ovf  = 0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; smp_valid = 1'b0; smp_data = '0; fb_in = '0; flush = 1'b0;
        model_clear();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill: 400, -400, 100 -> taps 25 / -100 / 100 on the third accept
        step("fill1", 1, 400, 0, 0);
        step("fill2", 1, -400, 0, 0);
        step("fill3", 1, 100, 0, 0);
        chk("fill3.tap1_abs", int'(tap1), 25);
        chk("fill3.win_abs", int'(win_valid), 1);
        step("idle", 0, 0, 0, 0);

        // Range extremes
        step("rng_pos", 1, 2047, 3, 0);
`ifdef NN_TAP_SAT_EN
        chk("rng_pos.tap1_abs", int'(tap1), 255);
`else
        chk("rng_pos.tap1_abs", int'(tap1), -1);
`endif
        step("rng_neg", 1, -2048, 3, 0);
        chk("rng_neg.ovf_cnt_abs", int'(ovf_cnt), 2);

        // Streaming with negative feedback
        step("flush0", 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("stream", 1, 40 * i - 90, -128, 0);
        chk("stream.tap4_abs", int'(tap4), -128);

        // Flush wins over a simultaneous sample
        step("flush_pri", 1, 100, 5, 1);
        step("post_flush1", 1, 8, 1, 0);
        step("post_flush2", 1, 12, 2, 0);

        // Async reset between edges, mid-fill
        step("pre_rst", 1, -20, 7, 1);
        step("pre_rst1", 1, 500, 7, 0);
        step("pre_rst2", 1, 1600, 7, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("refill1", 1, 4, 9, 0);
        step("refill2", 1, 8, 9, 0);
        step("refill3", 1, 12, 9, 0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 24) == 0));
        end

        // Counter saturation
        step("sat_flush", 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) step("sat", 1, 2047, 0, 0);
        chk("sat.ovf_cnt_abs", int'(ovf_cnt), 255);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

`default_nettype wire
